// File: rtl/yutorina_chip.sv
// Yutorina single-chip system: 32-bit multicycle CPU, instruction ROM,
// scratchpad data RAM (SPM) and one memory-mapped GPIO output register.
// Ports (top, yutorina_chip):
//   clk_ref  - system clock, all state changes on its rising edge
//   rst_sw   - synchronous active-high reset
//   gpio_out - GPIO output register (32 bits)
//   halted   - high once a HALT instruction has executed
//   pc_out   - current PC as an 11-bit word index
// Memory arrays named `memory` live at chip.rom and chip.cpu.spm.

// Instruction ROM: synchronous read, one-cycle latency. The load port is
// only for preloading and is tied off at the top level.
module yutorina_rom #(
  parameter int unsigned AW = 11
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output logic [31:0]   rdata,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data
);
  localparam int unsigned DEPTH = 2 ** AW;

  logic [31:0] memory [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (load_we) memory[load_addr] <= load_data;
    rdata_q <= memory[addr];
  end

  assign rdata = rdata_q;
endmodule

// Scratchpad RAM: two synchronous ports; a read that collides with a write
// to the same word returns the old contents.
module yutorina_spm #(
  parameter int unsigned AW = 12
) (
  input  logic          clk,
  input  logic          a_en,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [31:0]   a_wdata,
  output logic [31:0]   a_rdata,
  input  logic          b_en,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [31:0]   b_wdata,
  output logic [31:0]   b_rdata
);
  localparam int unsigned DEPTH = 2 ** AW;

  logic [31:0] memory [DEPTH];
  logic [31:0] a_rdata_q;
  logic [31:0] b_rdata_q;

  always_ff @(posedge clk) begin
    if (a_en) begin
      if (a_we) memory[a_addr] <= a_wdata;
      a_rdata_q <= memory[a_addr];
    end
    if (b_en) begin
      if (b_we) memory[b_addr] <= b_wdata;
      b_rdata_q <= memory[b_addr];
    end
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;
endmodule

// Multicycle CPU core: FETCH -> EXEC (-> MEM for loads) with SPM and GPIO.
module yutorina_cpu #(
  parameter int unsigned ROM_AW    = 11,
  parameter int unsigned SPM_AW    = 12,
  parameter logic [31:0] GPIO_BASE = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_rdata,
  output logic [31:0]       gpio_out,
  output logic              halted,
  output logic [10:0]       pc_out
);
  localparam int unsigned NREG = 32;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_SUB  = 6'h01;
  localparam logic [5:0] OP_AND  = 6'h02;
  localparam logic [5:0] OP_OR   = 6'h03;
  localparam logic [5:0] OP_XOR  = 6'h04;
  localparam logic [5:0] OP_SHL  = 6'h05;
  localparam logic [5:0] OP_SHR  = 6'h06;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h09;
  localparam logic [5:0] OP_LUI  = 6'h0A;
  localparam logic [5:0] OP_LD   = 6'h10;
  localparam logic [5:0] OP_ST   = 6'h11;
  localparam logic [5:0] OP_BEQ  = 6'h18;
  localparam logic [5:0] OP_BNE  = 6'h19;
  localparam logic [5:0] OP_JAL  = 6'h1A;
  localparam logic [5:0] OP_HALT = 6'h3F;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [10:0] pc_q, pc_d;
  logic [31:0] regs_q [NREG];
  logic [31:0] regs_d [NREG];
  logic [31:0] gpio_q, gpio_d;
  logic        halted_q, halted_d;

  // Instruction decode straight from the ROM output register.
  logic [5:0]  op;
  logic [4:0]  ra_idx, rb_idx, rc_idx;
  logic [15:0] imm;
  logic [31:0] ra_val, rb_val, imm_sext, imm_zext, eff_addr;
  logic        is_gpio;
  logic [10:0] pc_inc;

  assign op       = rom_rdata[31:26];
  assign ra_idx   = rom_rdata[25:21];
  assign rb_idx   = rom_rdata[20:16];
  assign rc_idx   = rom_rdata[15:11];
  assign imm      = rom_rdata[15:0];
  assign ra_val   = regs_q[ra_idx];
  assign rb_val   = regs_q[rb_idx];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'h0000, imm};
  assign eff_addr = ra_val + imm_sext;
  assign is_gpio  = |(eff_addr & GPIO_BASE);
  assign pc_inc   = pc_q + 11'd1;

  // SPM port A; a store in a reset cycle must not land.
  logic              spm_en, spm_we;
  logic [SPM_AW-1:0] spm_addr;
  logic [31:0]       spm_rdata;
  logic [31:0]       spm_b_rdata_unused;

  assign spm_en   = (state_q == ST_EXEC) && ((op == OP_LD) || (op == OP_ST)) && !is_gpio;
  assign spm_we   = spm_en && (op == OP_ST) && !rst;
  assign spm_addr = eff_addr[SPM_AW+1:2];

  yutorina_spm #(.AW(SPM_AW)) spm (
    .clk     (clk),
    .a_en    (spm_en),
    .a_we    (spm_we),
    .a_addr  (spm_addr),
    .a_wdata (rb_val),
    .a_rdata (spm_rdata),
    .b_en    (1'b0),
    .b_we    (1'b0),
    .b_addr  ('0),
    .b_wdata ('0),
    .b_rdata (spm_b_rdata_unused)
  );

  logic        wr_en;
  logic [4:0]  wr_idx;
  logic [31:0] wr_val;

  // Next-state, register write-back and PC update.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    regs_d   = regs_q;
    gpio_d   = gpio_q;
    halted_d = halted_q;
    wr_en    = 1'b0;
    wr_idx   = rc_idx;
    wr_val   = '0;

    case (state_q)
      ST_FETCH: state_d = ST_EXEC;

      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_inc;
        case (op)
          OP_ADD:  begin wr_en = 1'b1; wr_val = ra_val + rb_val;        end
          OP_SUB:  begin wr_en = 1'b1; wr_val = ra_val - rb_val;        end
          OP_AND:  begin wr_en = 1'b1; wr_val = ra_val & rb_val;        end
          OP_OR:   begin wr_en = 1'b1; wr_val = ra_val | rb_val;        end
          OP_XOR:  begin wr_en = 1'b1; wr_val = ra_val ^ rb_val;        end
          OP_SHL:  begin wr_en = 1'b1; wr_val = ra_val << rb_val[4:0];  end
          OP_SHR:  begin wr_en = 1'b1; wr_val = ra_val >> rb_val[4:0];  end
          OP_ADDI: begin wr_en = 1'b1; wr_idx = rb_idx; wr_val = ra_val + imm_sext; end
          OP_ORI:  begin wr_en = 1'b1; wr_idx = rb_idx; wr_val = ra_val | imm_zext; end
          OP_LUI:  begin wr_en = 1'b1; wr_idx = rb_idx; wr_val = {imm, 16'h0000}; end
          OP_LD: begin
            pc_d    = pc_q;
            state_d = ST_MEM;
          end
          OP_ST: begin
            if (is_gpio) gpio_d = rb_val;
          end
          OP_BEQ: begin
            if (ra_val == rb_val) pc_d = pc_inc + imm[10:0];
          end
          OP_BNE: begin
            if (ra_val != rb_val) pc_d = pc_inc + imm[10:0];
          end
          OP_JAL: begin
            // Target comes from the pre-write value of ra, even when rb == ra.
            wr_en  = 1'b1;
            wr_idx = rb_idx;
            wr_val = 32'(pc_inc);
            pc_d   = ra_val[10:0];
          end
          OP_HALT: begin
            pc_d     = pc_q;
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end
          default: ;
        endcase
      end

      // PC was held during EXEC, so the ROM still shows the same LD and
      // the register file is unchanged: the decode above is still valid.
      ST_MEM: begin
        wr_en   = 1'b1;
        wr_idx  = rb_idx;
        wr_val  = is_gpio ? gpio_q : spm_rdata;
        pc_d    = pc_inc;
        state_d = ST_FETCH;
      end

      ST_HALT: ;

      default: state_d = ST_FETCH;
    endcase

    if (wr_en && (wr_idx != 5'd0)) regs_d[wr_idx] = wr_val;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      pc_q     <= '0;
      gpio_q   <= '0;
      halted_q <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      gpio_q   <= gpio_d;
      halted_q <= halted_d;
      regs_q   <= regs_d;
    end
  end

  assign rom_addr = ROM_AW'(pc_q);
  assign gpio_out = gpio_q;
  assign halted   = halted_q;
  assign pc_out   = pc_q;
endmodule

// Chip top: ROM plus CPU (which owns the SPM and GPIO register).
module yutorina_chip #(
  parameter int unsigned ROM_AW    = 11,
  parameter int unsigned SPM_AW    = 12,
  parameter logic [31:0] GPIO_BASE = 32'h8000_0000
) (
  input  logic        clk_ref,
  input  logic        rst_sw,
  output logic [31:0] gpio_out,
  output logic        halted,
  output logic [10:0] pc_out
);
  logic [ROM_AW-1:0] rom_addr;
  logic [31:0]       rom_rdata;

  yutorina_rom #(.AW(ROM_AW)) rom (
    .clk       (clk_ref),
    .addr      (rom_addr),
    .rdata     (rom_rdata),
    .load_we   (1'b0),
    .load_addr ('0),
    .load_data ('0)
  );

  yutorina_cpu #(
    .ROM_AW    (ROM_AW),
    .SPM_AW    (SPM_AW),
    .GPIO_BASE (GPIO_BASE)
  ) cpu (
    .clk       (clk_ref),
    .rst       (rst_sw),
    .rom_addr  (rom_addr),
    .rom_rdata (rom_rdata),
    .gpio_out  (gpio_out),
    .halted    (halted),
    .pc_out    (pc_out)
  );
endmodule

// File: tb/tb_yutorina_chip.sv
// Self-checking bench for yutorina_chip: directed programs plus random
// programs, each compared against an instruction-level model of the ISA.
module tb_yutorina_chip;
  logic        clk_ref = 1'b0;
  logic        rst_sw  = 1'b1;
  logic [31:0] gpio_out;
  logic        halted;
  logic [10:0] pc_out;

  always #5 clk_ref = ~clk_ref;

  yutorina_chip chip (
    .clk_ref  (clk_ref),
    .rst_sw   (rst_sw),
    .gpio_out (gpio_out),
    .halted   (halted),
    .pc_out   (pc_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Instruction-level model state.
  logic [31:0] m_rom  [2048];
  logic [31:0] m_spm  [4096];
  logic [31:0] m_regs [32];
  logic [31:0] m_gpio;
  logic [10:0] m_pc;
  int          m_cyc;

  localparam logic [31:0] W_HALT = 32'hFC00_0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] ra,
                                        input logic [4:0] rb, input logic [4:0] rc);
    return {op, ra, rb, rc, 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] ra,
                                        input logic [4:0] rb, input logic [15:0] imm);
    return {op, ra, rb, imm};
  endfunction

  task automatic put(input int idx, input logic [31:0] w);
    m_rom[idx] = w;
    chip.rom.memory[idx] = w;
  endtask

  task automatic spm_set(input int idx, input logic [31:0] w);
    m_spm[idx] = w;
    chip.cpu.spm.memory[idx] = w;
  endtask

  // Fill ROM with HALT and SPM with random words, identically in model and DUT.
  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) put(i, W_HALT);
    for (int i = 0; i < 4096; i++) spm_set(i, $urandom);
  endtask

  function automatic void m_wr(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_regs[r] = v;
  endfunction

  // Execute the ISA from pc 0 until HALT; 2 cycles per instruction, 3 per LD.
  task automatic model_run();
    logic [31:0] ins, a, b, sx, ea;
    logic [5:0]  op;
    logic [4:0]  ra, rb, rc;
    logic [10:0] pc, npc;
    pc = '0;
    m_gpio = '0;
    m_cyc = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    for (int s = 0; s < 20000; s++) begin
      ins = m_rom[pc];
      op = ins[31:26]; ra = ins[25:21]; rb = ins[20:16]; rc = ins[15:11];
      a = m_regs[ra]; b = m_regs[rb];
      sx = {{16{ins[15]}}, ins[15:0]};
      ea = a + sx;
      npc = pc + 11'd1;
      m_cyc += 2;
      if (op == 6'h3F) begin
        m_pc = pc;
        return;
      end
      case (op)
        6'h00: m_wr(rc, a + b);
        6'h01: m_wr(rc, a - b);
        6'h02: m_wr(rc, a & b);
        6'h03: m_wr(rc, a | b);
        6'h04: m_wr(rc, a ^ b);
        6'h05: m_wr(rc, a << b[4:0]);
        6'h06: m_wr(rc, a >> b[4:0]);
        6'h08: m_wr(rb, a + sx);
        6'h09: m_wr(rb, a | {16'h0, ins[15:0]});
        6'h0A: m_wr(rb, {ins[15:0], 16'h0});
        6'h10: begin
          m_cyc += 1;
          m_wr(rb, ea[31] ? m_gpio : m_spm[ea[13:2]]);
        end
        6'h11: begin
          if (ea[31]) m_gpio = b;
          else m_spm[ea[13:2]] = b;
        end
        6'h18: if (a == b) npc = pc + 11'd1 + sx[10:0];
        6'h19: if (a != b) npc = pc + 11'd1 + sx[10:0];
        6'h1A: begin
          m_wr(rb, {21'd0, pc + 11'd1});
          npc = a[10:0];
        end
        default: ;
      endcase
      pc = npc;
    end
    m_pc = pc;
  endtask

  task automatic reset_dut();
    @(negedge clk_ref);
    rst_sw = 1'b1;
    repeat (2) @(posedge clk_ref);
    @(negedge clk_ref);
    rst_sw = 1'b0;
  endtask

  // Count rising edges until halted, bounded by limit.
  task automatic run_to_halt(input int limit, inout int cyc);
    while (!halted && cyc < limit) begin
      @(posedge clk_ref);
      #1;
      cyc++;
    end
  endtask

  task automatic check_all(input string tag, input int cyc);
    int bad;
    chk({tag, " halted"}, 32'(halted), 32'd1);
    chk({tag, " cycles"}, 32'(cyc), 32'(m_cyc));
    chk({tag, " pc"}, 32'(pc_out), 32'(m_pc));
    chk({tag, " gpio"}, gpio_out, m_gpio);
    for (int i = 0; i < 32; i++)
      chk($sformatf("%s r%0d", tag, i), chip.cpu.regs_q[i], m_regs[i]);
    bad = 0;
    for (int i = 0; i < 4096; i++)
      if (chip.cpu.spm.memory[i] !== m_spm[i]) bad++;
    chk({tag, " spm words differing"}, 32'(bad), 32'd0);
  endtask

  task automatic gen_random(input int n);
    int          k;
    logic [4:0]  ra, rb, rc;
    logic [15:0] imm;
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      k   = int'($urandom_range(0, 15));
      ra  = 5'($urandom_range(0, 7));
      rb  = 5'($urandom_range(0, 7));
      rc  = 5'($urandom_range(0, 7));
      imm = 16'($urandom);
      case (k)
        0, 1, 2, 3, 4, 5, 6: w = enc_r(6'(k), ra, rb, rc);
        7:  w = enc_i(6'h08, ra, rb, imm);
        8:  w = enc_i(6'h09, ra, rb, imm);
        9:  w = enc_i(6'h0A, ra, rb, imm);
        10: w = enc_i(6'h10, 5'd0, rb, imm);
        11: w = enc_i(6'h11, 5'd0, rb, imm);
        12: w = enc_i(6'h18, ra, rb, 16'($urandom_range(0, 3)));
        13: w = enc_i(6'h19, ra, rb, 16'($urandom_range(0, 3)));
        14: w = enc_i(($urandom_range(0, 1) != 0) ? 6'h07 : 6'h2A, ra, rb, imm);
        default: w = enc_i(($urandom_range(0, 1) != 0) ? 6'h10 : 6'h11, ra, rb, imm);
      endcase
      put(i, w);
    end
  endtask

  initial begin
    int cyc;

    // ALU + GPIO program, also used for the reset checks.
    clear_mem();
    put(0, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
    put(1, enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD));
    put(2, enc_r(6'h00, 5'd1, 5'd2, 5'd3));
    put(3, enc_r(6'h01, 5'd2, 5'd1, 5'd4));
    put(4, enc_i(6'h0A, 5'd0, 5'd6, 16'h8000));
    put(5, enc_i(6'h11, 5'd6, 5'd3, 16'h0000));
    put(6, enc_i(6'h0A, 5'd0, 5'd5, 16'h1234));
    put(7, enc_i(6'h09, 5'd5, 5'd5, 16'h5678));
    put(8, W_HALT);
    reset_dut();
    chk("reset pc", 32'(pc_out), 32'd0);
    chk("reset gpio", gpio_out, 32'd0);
    chk("reset halted", 32'(halted), 32'd0);
    @(posedge clk_ref); #1;
    chk("fetch holds pc", 32'(pc_out), 32'd0);
    @(posedge clk_ref); #1;
    chk("first exec pc", 32'(pc_out), 32'd1);
    cyc = 2;
    run_to_halt(1000, cyc);
    model_run();
    check_all("alu", cyc);
    chk("alu gpio const", gpio_out, 32'd2);
    chk("alu r4 const", chip.cpu.regs_q[4], 32'hFFFF_FFF8);
    chk("alu r5 const", chip.cpu.regs_q[5], 32'h1234_5678);
    chk("alu pc const", 32'(pc_out), 32'd8);
    repeat (3) @(posedge clk_ref);
    #1;
    chk("halt pc frozen", 32'(pc_out), 32'd8);

    // Load/store through SPM and GPIO, including a GPIO load.
    clear_mem();
    spm_set(3, 32'hDEAD_BEEF);
    put(0, enc_i(6'h10, 5'd0, 5'd1, 16'd12));
    put(1, enc_i(6'h11, 5'd0, 5'd1, 16'd16));
    put(2, enc_i(6'h10, 5'd0, 5'd2, 16'd16));
    put(3, enc_i(6'h0A, 5'd0, 5'd6, 16'h8000));
    put(4, enc_i(6'h11, 5'd6, 5'd2, 16'd0));
    put(5, enc_i(6'h10, 5'd6, 5'd7, 16'd4));
    reset_dut();
    cyc = 0;
    run_to_halt(1000, cyc);
    model_run();
    check_all("ldst", cyc);
    chk("ldst gpio const", gpio_out, 32'hDEAD_BEEF);
    chk("ldst spm4 const", chip.cpu.spm.memory[4], 32'hDEAD_BEEF);
    chk("ldst gpio load", chip.cpu.regs_q[7], 32'hDEAD_BEEF);

    // Counting loop with BNE.
    clear_mem();
    put(0, enc_i(6'h08, 5'd0, 5'd2, 16'd10));
    put(1, enc_i(6'h08, 5'd1, 5'd1, 16'd1));
    put(2, enc_i(6'h19, 5'd1, 5'd2, 16'hFFFE));
    put(3, enc_i(6'h0A, 5'd0, 5'd6, 16'h8000));
    put(4, enc_i(6'h11, 5'd6, 5'd1, 16'd0));
    reset_dut();
    cyc = 0;
    run_to_halt(1000, cyc);
    model_run();
    check_all("loop", cyc);
    chk("loop gpio const", gpio_out, 32'd10);
    chk("loop cycles const", 32'(cyc), 32'd48);

    // JAL to the last ROM word and wrap back to 0.
    clear_mem();
    put(0, enc_i(6'h19, 5'd8, 5'd0, 16'd3));
    put(1, enc_i(6'h08, 5'd0, 5'd7, 16'd2047));
    put(2, enc_i(6'h1A, 5'd7, 5'd31, 16'd0));
    put(4, enc_i(6'h0A, 5'd0, 5'd6, 16'h8000));
    put(5, enc_i(6'h11, 5'd6, 5'd31, 16'd0));
    put(2047, enc_i(6'h08, 5'd8, 5'd8, 16'd1));
    reset_dut();
    repeat (6) @(posedge clk_ref);
    #1;
    chk("jal target pc", 32'(pc_out), 32'd2047);
    repeat (2) @(posedge clk_ref);
    #1;
    chk("pc wrap", 32'(pc_out), 32'd0);
    cyc = 8;
    run_to_halt(1000, cyc);
    model_run();
    check_all("jal", cyc);
    chk("jal link const", chip.cpu.regs_q[31], 32'd3);

    // Reset landing in the EXEC cycle of a GPIO store.
    clear_mem();
    put(0, enc_i(6'h08, 5'd0, 5'd1, 16'h00FF));
    put(1, enc_i(6'h0A, 5'd0, 5'd2, 16'h8000));
    put(2, enc_i(6'h11, 5'd2, 5'd1, 16'd0));
    reset_dut();
    repeat (5) @(posedge clk_ref);
    #1;
    chk("store exec pc", 32'(pc_out), 32'd2);
    rst_sw = 1'b1;
    @(posedge clk_ref); #1;
    chk("abort gpio", gpio_out, 32'd0);
    chk("abort pc", 32'(pc_out), 32'd0);
    chk("abort r1", chip.cpu.regs_q[1], 32'd0);
    @(negedge clk_ref);
    rst_sw = 1'b0;
    cyc = 0;
    run_to_halt(1000, cyc);
    model_run();
    check_all("rerun", cyc);

    // Random programs against the model.
    for (int t = 0; t < 8; t++) begin
      clear_mem();
      gen_random(24);
      reset_dut();
      cyc = 0;
      run_to_halt(2000, cyc);
      model_run();
      check_all($sformatf("rand%0d", t), cyc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
